leaf_rx_depacketizer: RTL and testbench

Receive-side leaf interface that sits between one BFT leaf port and the page that port serves. It takes 49-bit BFT packets, checks the destination leaf address, and queues accepted payloads in a small FIFO. It presents them to the page as a valid/ready stream. When the FIFO cannot take a packet, the packet is bounced back toward the BFT on the interface-to-BFT bus with `resend` pulsed.

---
 rtl/leaf_rx_depacketizer_pkg.sv | 45 ++++
 rtl/leaf_rx_depacketizer_if.sv | 24 ++
 rtl/leaf_rx_fifo.sv | 60 ++++++
 rtl/leaf_rx_depacketizer.sv | 92 +++++++++
 tb/tb_leaf_rx_depacketizer.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/leaf_rx_depacketizer_pkg.sv
// BFT packet layout shared by the leaf receive path: field positions, extract helpers
// and the stage-1 classification of a registered packet.
package leaf_pkt_pkg;

  localparam int PKT_W     = 49;
  localparam int VALID_BIT = 48;
  localparam int ADDR_HI   = 47;
  localparam int ADDR_LO   = 43;
  localparam int PORT_HI   = 42;
  localparam int PORT_LO   = 39;
  localparam int TAG_HI    = 38;
  localparam int TAG_LO    = 32;
  localparam int DATA_HI   = 31;
  localparam int DATA_LO   = 0;
  localparam int ENTRY_W   = 36;

  typedef logic [PKT_W-1:0] pkt_t;

  typedef enum logic [1:0] {
    ACT_NONE,
    ACT_PUSH,
    ACT_BOUNCE,
    ACT_DROP
  } rx_action_t;

  function automatic logic [3:0] pkt_port(pkt_t p);
    return p[PORT_HI:PORT_LO];
  endfunction

  function automatic logic [31:0] pkt_data(pkt_t p);
    return p[DATA_HI:DATA_LO];
  endfunction

  // Full is the occupancy before any same-cycle pop, so a full FIFO always bounces.
  function automatic rx_action_t classify(pkt_t p, logic [4:0] leaf, logic full);
    if (!p[VALID_BIT]) return ACT_NONE;
    if (p[ADDR_HI:ADDR_LO] != leaf) return ACT_DROP;
    return full ? ACT_BOUNCE : ACT_PUSH;
  endfunction

  function automatic logic [15:0] sat_inc16(logic [15:0] v, logic en);
    return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

endpackage

// File: rtl/leaf_rx_depacketizer_if.sv
// Leaf-side bus bundle: BFT packet in, bounce path back to BFT, payload stream to the page.
interface leaf_rx_depacketizer_if;
  import leaf_pkt_pkg::*;

  pkt_t        din_leaf_bft2interface;
  pkt_t        dout_leaf_interface2bft;
  logic        resend;
  logic        ap_start;
  logic [31:0] dout;
  logic [3:0]  dout_port;
  logic        dout_valid;
  logic        dout_ready;
  logic        addr_err;

  modport slave (
    input  din_leaf_bft2interface, ap_start, dout_ready,
    output dout_leaf_interface2bft, resend, dout, dout_port, dout_valid, addr_err
  );

  modport master (
    output din_leaf_bft2interface, ap_start, dout_ready,
    input  dout_leaf_interface2bft, resend, dout, dout_port, dout_valid, addr_err
  );
endinterface

// File: rtl/leaf_rx_fifo.sv
// Synchronous first-word-fall-through FIFO; DEPTH must be a power of two so pointers wrap freely.
module leaf_rx_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o,
  output logic                       full_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/leaf_rx_depacketizer.sv
// BFT leaf receive path: register packet, check address, queue {port,payload} or bounce when full.
// Defining LEAF_RX_STATS_EN adds 16-bit saturating accept/bounce/address-error counters.
module leaf_rx_depacketizer
  import leaf_pkt_pkg::*;
#(
  parameter logic [4:0] LEAF_ADDR  = 5'd0,
  parameter int         FIFO_DEPTH = 16
) (
  input  logic clk,
  input  logic reset,
`ifdef LEAF_RX_STATS_EN
  output logic [15:0] stat_accepted,
  output logic [15:0] stat_bounced,
  output logic [15:0] stat_addr_err,
`endif
  leaf_rx_depacketizer_if.slave bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  pkt_t               pkt_q, bounce_q, bounce_d;
  logic               resend_q, resend_d, addr_err_q, addr_err_d;
  rx_action_t         act;
  logic               fifo_full, fifo_empty, fifo_pop;
  logic [ENTRY_W-1:0] fifo_rdata;
  logic [CW-1:0]      fifo_count_unused;

  always_comb begin
    act        = classify(pkt_q, LEAF_ADDR, fifo_full);
    resend_d   = (act == ACT_BOUNCE);
    addr_err_d = (act == ACT_DROP);
    bounce_d   = (act == ACT_BOUNCE) ? pkt_q : bounce_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_q      <= '0;
      bounce_q   <= '0;
      resend_q   <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      pkt_q      <= bus.din_leaf_bft2interface;
      bounce_q   <= bounce_d;
      resend_q   <= resend_d;
      addr_err_q <= addr_err_d;
    end
  end

  leaf_rx_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .push_i  (act == ACT_PUSH),
    .wdata_i ({pkt_port(pkt_q), pkt_data(pkt_q)}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count_unused),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // ap_start only gates the page-side stream; filling and bouncing continue regardless.
  assign bus.dout_valid              = !fifo_empty && bus.ap_start;
  assign fifo_pop                    = bus.dout_valid && bus.dout_ready;
  assign bus.dout                    = fifo_rdata[31:0];
  assign bus.dout_port               = fifo_rdata[35:32];
  assign bus.dout_leaf_interface2bft = bounce_q;
  assign bus.resend                  = resend_q;
  assign bus.addr_err                = addr_err_q;

`ifdef LEAF_RX_STATS_EN
  logic [15:0] st_acc_q, st_bnc_q, st_aer_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_acc_q <= '0;
      st_bnc_q <= '0;
      st_aer_q <= '0;
    end else begin
      st_acc_q <= sat_inc16(st_acc_q, act == ACT_PUSH);
      st_bnc_q <= sat_inc16(st_bnc_q, act == ACT_BOUNCE);
      st_aer_q <= sat_inc16(st_aer_q, act == ACT_DROP);
    end
  end

  assign stat_accepted = st_acc_q;
  assign stat_bounced  = st_bnc_q;
  assign stat_addr_err = st_aer_q;
`endif

endmodule

// File: tb/tb_leaf_rx_depacketizer.sv
// Self-checking bench for leaf_rx_depacketizer: queue-based reference model plus directed literal checks.
module tb_leaf_rx_depacketizer;
  import leaf_pkt_pkg::*;

  localparam logic [4:0] LEAF  = 5'd0;
  localparam int         DEPTH = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  leaf_rx_depacketizer_if bus();

`ifdef LEAF_RX_STATS_EN
  logic [15:0] s_acc, s_bnc, s_aer;
`endif

  leaf_rx_depacketizer #(
    .LEAF_ADDR  (LEAF),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
`ifdef LEAF_RX_STATS_EN
    .stat_accepted (s_acc),
    .stat_bounced  (s_bnc),
    .stat_addr_err (s_aer),
`endif
    .bus           (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: expected queue contents and expected registered outputs.
  logic [35:0] mq[$];
  logic [48:0] m_pkt    = '0;
  logic [48:0] e_bounce = '0;
  bit          e_resend = 1'b0;
  bit          e_aerr   = 1'b0;
  int          m_acc = 0, m_bnc = 0, m_aer = 0;
  bit          chk_en = 1'b0;

  function automatic logic [48:0] mk(bit v, logic [4:0] a, logic [3:0] p, logic [6:0] t, logic [31:0] d);
    return {v, a, p, t, d};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge reset) begin : model
    int occ;
    bit pop, push;
    if (reset) begin
      mq.delete();
      m_pkt    = '0;
      e_bounce = '0;
      e_resend = 1'b0;
      e_aerr   = 1'b0;
      m_acc    = 0;
      m_bnc    = 0;
      m_aer    = 0;
    end else begin
      occ  = mq.size();
      pop  = (occ != 0) && bus.ap_start && bus.dout_ready;
      push = 1'b0;
      e_resend = 1'b0;
      e_aerr   = 1'b0;
      if (m_pkt[48]) begin
        if (m_pkt[47:43] != LEAF) begin
          e_aerr = 1'b1;
          if (m_aer < 65535) m_aer++;
        end else if (occ < DEPTH) begin
          push = 1'b1;
          if (m_acc < 65535) m_acc++;
        end else begin
          e_resend = 1'b1;
          e_bounce = m_pkt;
          if (m_bnc < 65535) m_bnc++;
        end
      end
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back({m_pkt[42:39], m_pkt[31:0]});
      m_pkt = bus.din_leaf_bft2interface;
    end
  end

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      chk("resend", 64'(bus.resend), 64'(e_resend));
      chk("addr_err", 64'(bus.addr_err), 64'(e_aerr));
      chk("bounce_pkt", 64'(bus.dout_leaf_interface2bft), 64'(e_bounce));
      chk("dout_valid", 64'(bus.dout_valid), 64'((mq.size() != 0) && bus.ap_start));
      if ((mq.size() != 0) && bus.ap_start) begin
        chk("dout", 64'(bus.dout), 64'(mq[0][31:0]));
        chk("dout_port", 64'(bus.dout_port), 64'(mq[0][35:32]));
      end
`ifdef LEAF_RX_STATS_EN
      chk("stat_accepted", 64'(s_acc), 64'(m_acc));
      chk("stat_bounced", 64'(s_bnc), 64'(m_bnc));
      chk("stat_addr_err", 64'(s_aer), 64'(m_aer));
`endif
    end
  end

  task automatic drive(logic [48:0] p, bit ap, bit rdy);
    @(posedge clk);
    #1;
    bus.din_leaf_bft2interface = p;
    bus.ap_start               = ap;
    bus.dout_ready             = rdy;
  endtask

  logic [48:0] p16, px, pr;

  initial begin
    bus.din_leaf_bft2interface = '0;
    bus.ap_start               = 1'b1;
    bus.dout_ready             = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_resend", 64'(bus.resend), 64'd0);
    chk("rst_bounce", 64'(bus.dout_leaf_interface2bft), 64'd0);
    chk("rst_addr_err", 64'(bus.addr_err), 64'd0);
    chk("rst_dout_valid", 64'(bus.dout_valid), 64'd0);
    reset  = 1'b0;
    chk_en = 1'b1;

    // Single accepted packet: visible two cycles after it is presented.
    drive(mk(1, LEAF, 4'd3, 7'd5, 32'hDEADBEEF), 1, 1);
    drive('0, 1, 1);
    @(negedge clk);
    chk("t1_early_valid", 64'(bus.dout_valid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("t1_valid", 64'(bus.dout_valid), 64'd1);
    chk("t1_dout", 64'(bus.dout), 64'hDEADBEEF);
    chk("t1_port", 64'(bus.dout_port), 64'd3);
    chk("t1_resend", 64'(bus.resend), 64'd0);

    // Misaddressed packet.
    drive(mk(1, LEAF ^ 5'd1, 4'd2, 7'd0, 32'h1234), 1, 1);
    drive('0, 1, 1);
    @(posedge clk);
    @(negedge clk);
    chk("t2_addr_err", 64'(bus.addr_err), 64'd1);
    chk("t2_valid", 64'(bus.dout_valid), 64'd0);
    chk("t2_resend", 64'(bus.resend), 64'd0);
    @(negedge clk);
    chk("t2_addr_err_off", 64'(bus.addr_err), 64'd0);

    // 17 back-to-back packets with no pops: the 17th bounces.
    for (int k = 0; k < 17; k++) drive(mk(1, LEAF, 4'(k), 7'(k), 32'(k)), 1, 0);
    p16 = mk(1, LEAF, 4'(16), 7'(16), 32'd16);
    drive('0, 1, 0);
    @(posedge clk);
    @(negedge clk);
    chk("t3_resend", 64'(bus.resend), 64'd1);
    chk("t3_bounce", 64'(bus.dout_leaf_interface2bft), 64'(p16));
    chk("t3_head", 64'(bus.dout), 64'd0);
    @(negedge clk);
    chk("t3_resend_off", 64'(bus.resend), 64'd0);

    // Full FIFO with a pop in the same cycle the new packet is classified.
    px = mk(1, LEAF, 4'd9, 7'h7F, 32'hCAFE0001);
    drive(px, 1, 0);
    drive('0, 1, 1);
    drive('0, 1, 0);
    @(negedge clk);
    chk("t4_resend", 64'(bus.resend), 64'd1);
    chk("t4_bounce", 64'(bus.dout_leaf_interface2bft), 64'(px));
    chk("t4_head", 64'(bus.dout), 64'd1);
    repeat (20) drive('0, 1, 1);

    // ap_start low holds the queue; raising it drains in order.
    for (int k = 0; k < 4; k++) drive(mk(1, LEAF, 4'(k + 4), 7'd0, 32'(100 + k)), 0, 1);
    repeat (3) drive('0, 0, 1);
    @(negedge clk);
    chk("t5_held", 64'(bus.dout_valid), 64'd0);
    drive('0, 1, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t5_drain_valid", 64'(bus.dout_valid), 64'd1);
      chk("t5_drain_dout", 64'(bus.dout), 64'(100 + k));
    end
    @(negedge clk);
    chk("t5_empty", 64'(bus.dout_valid), 64'd0);

    // Asynchronous reset with 8 entries queued.
    for (int k = 0; k < 8; k++) drive(mk(1, LEAF, 4'd1, 7'd0, 32'(200 + k)), 0, 0);
    repeat (3) drive('0, 0, 0);
    @(negedge clk);
    bus.ap_start = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk("t6_resend", 64'(bus.resend), 64'd0);
    chk("t6_bounce", 64'(bus.dout_leaf_interface2bft), 64'd0);
    chk("t6_addr_err", 64'(bus.addr_err), 64'd0);
    chk("t6_valid", 64'(bus.dout_valid), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    pr = mk(1, LEAF, 4'd7, 7'd1, 32'h12345678);
    drive(pr, 1, 1);
    drive('0, 1, 1);
    @(posedge clk);
    @(negedge clk);
    chk("t6_after_valid", 64'(bus.dout_valid), 64'd1);
    chk("t6_after_dout", 64'(bus.dout), 64'h12345678);
    chk("t6_after_port", 64'(bus.dout_port), 64'd7);

    // Randomized traffic: a congested phase then a draining phase.
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 1500; i++) begin
        logic [4:0] a;
        a = ($urandom_range(0, 4) == 0) ? 5'($urandom) : LEAF;
        drive(mk($urandom_range(0, 9) < 7, a, 4'($urandom), 7'($urandom), $urandom),
              $urandom_range(0, 9) < 8,
              (ph == 0) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 9));
      end
    end
    repeat (40) drive('0, 1, 1);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
